// File: rtl/board_matrix_scanner.sv
// Row-scanned bicolour LED driver for the 8x8 bubble board, one board snapshot per frame.
// Optional cursor blink overlay is enabled by defining CURSOR_BLINK_EN.
module board_matrix_scanner #(
  parameter int DIV          = 50000,
  parameter int BLANK        = 2,
  parameter int BLINK_FRAMES = 32
) (
  input  logic        CLK,
  input  logic        reset,
  input  logic [63:0] red,
  input  logic [63:0] blue,
  input  logic [5:0]  cursor,
  input  logic        turn,
  output logic [7:0]  row_sel,
  output logic [7:0]  red_col,
  output logic [7:0]  blue_col,
  output logic        frame_tick
);

  localparam int CW = (DIV > 2) ? $clog2(DIV) : 1;

  logic [CW-1:0] r_cnt, w_cnt_nx;
  logic [2:0]    r_row, w_row_nx;
  logic [63:0]   r_snap_r, r_snap_b;
  logic [63:0]   w_snap_r_nx, w_snap_b_nx;
  logic          r_primed;
  logic          w_wrap, w_frame, w_load;
  logic [7:0]    w_rs, w_rc, w_bc;
  logic [7:0]    r_rs, r_rc, r_bc;
  logic          r_ft;
  logic [5:0]    w_base;

`ifdef CURSOR_BLINK_EN
  localparam int FW = $clog2(BLINK_FRAMES) + 1;
  logic [5:0]    r_cur, w_cur_nx;
  logic          r_turn, w_turn_nx;
  logic [FW-1:0] r_fcnt, w_fcnt_nx;
  logic          r_phase, w_phase_nx;
`else
  logic w_unused;
  assign w_unused = ^{cursor, turn, BLINK_FRAMES[0]};
`endif

  assign row_sel    = r_rs;
  assign red_col    = r_rc;
  assign blue_col   = r_bc;
  assign frame_tick = r_ft;

  always_comb begin
    w_wrap      = (r_cnt == CW'(DIV - 1));
    w_cnt_nx    = w_wrap ? '0 : r_cnt + 1'b1;
    w_row_nx    = w_wrap ? r_row + 3'd1 : r_row;
    w_frame     = w_wrap && (r_row == 3'd7);
    w_load      = w_frame || !r_primed;
    w_snap_r_nx = w_load ? red  : r_snap_r;
    w_snap_b_nx = w_load ? blue : r_snap_b;
    w_base      = {w_row_nx, 3'b000};
    w_rs        = 8'd1 << w_row_nx;
    w_rc        = w_snap_r_nx[w_base +: 8];
    w_bc        = w_snap_b_nx[w_base +: 8];
`ifdef CURSOR_BLINK_EN
    w_cur_nx   = w_load ? cursor : r_cur;
    w_turn_nx  = w_load ? turn : r_turn;
    w_fcnt_nx  = r_fcnt;
    w_phase_nx = r_phase;
    if (w_frame) begin
      if (r_fcnt == FW'(BLINK_FRAMES - 1)) begin
        w_fcnt_nx  = '0;
        w_phase_nx = ~r_phase;
      end else begin
        w_fcnt_nx = r_fcnt + 1'b1;
      end
    end
    // Occupied cursor cell blinks dark; empty one blinks in the mover's colour.
    if (w_phase_nx && (w_cur_nx[5:3] == w_row_nx)) begin
      if (w_rc[w_cur_nx[2:0]] || w_bc[w_cur_nx[2:0]]) begin
        w_rc[w_cur_nx[2:0]] = 1'b0;
        w_bc[w_cur_nx[2:0]] = 1'b0;
      end else if (w_turn_nx) begin
        w_bc[w_cur_nx[2:0]] = 1'b1;
      end else begin
        w_rc[w_cur_nx[2:0]] = 1'b1;
      end
    end
`endif
    if (w_cnt_nx < CW'(BLANK)) begin
      w_rs = '0;
      w_rc = '0;
      w_bc = '0;
    end
  end

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      r_cnt    <= '0;
      r_row    <= '0;
      r_snap_r <= '0;
      r_snap_b <= '0;
      r_primed <= 1'b0;
      r_rs     <= '0;
      r_rc     <= '0;
      r_bc     <= '0;
      r_ft     <= 1'b0;
`ifdef CURSOR_BLINK_EN
      r_cur    <= '0;
      r_turn   <= 1'b0;
      r_fcnt   <= '0;
      r_phase  <= 1'b0;
`endif
    end else begin
      r_cnt    <= w_cnt_nx;
      r_row    <= w_row_nx;
      r_snap_r <= w_snap_r_nx;
      r_snap_b <= w_snap_b_nx;
      r_primed <= 1'b1;
      r_rs     <= w_rs;
      r_rc     <= w_rc;
      r_bc     <= w_bc;
      r_ft     <= w_frame;
`ifdef CURSOR_BLINK_EN
      r_cur    <= w_cur_nx;
      r_turn   <= w_turn_nx;
      r_fcnt   <= w_fcnt_nx;
      r_phase  <= w_phase_nx;
`endif
    end
  end

endmodule
